// File: rtl/rle_decompression.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rle_decompression                                              |
// | Purpose  : PackBits-style RLE decoder / bypass with pixel coordinates.    |
// |            Optional stats outputs when RLE_DECOMP_STATS_EN is defined.    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module rle_decompression #(
  parameter int H_RES = 1920,
  parameter int V_RES = 1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [7:0]  data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        sof,
  output logic        eol,
  output logic        err
`ifdef RLE_DECOMP_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [11:0] c_x_last = 12'(H_RES - 1);
  localparam logic [11:0] c_y_last = 12'(V_RES - 1);

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_RUN_VAL = 2'd1,
    S_RUN_OUT = 2'd2,
    S_LIT     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_cnt;
  logic [6:0]  w_cnt_nxt;
  logic [7:0]  r_val;
  logic [7:0]  r_data;
  logic        r_valid;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_err;
  logic        w_in_ready;
  logic        w_load;
  logic [7:0]  w_load_data;
  logic        w_hdr;
  logic        w_slot_free;
  logic        w_xfer;
  logic        w_x_last;
  logic        w_y_last;

  assign w_slot_free = !r_valid || out_ready;
  assign w_xfer      = enable && r_valid && out_ready;
  assign w_x_last    = (r_x == c_x_last);
  assign w_y_last    = (r_y == c_y_last);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_load_data = data_in;
    w_hdr       = 1'b0;
    case (r_state)
      S_HDR: begin
        if (mode == 2'b00) begin
          w_in_ready = enable && w_slot_free;
          if (in_valid && w_in_ready) w_load = 1'b1;
        end else if (mode == 2'b01) begin
          // Headers emit nothing, so they never wait on the output slot.
          w_in_ready = enable;
          if (in_valid && w_in_ready) begin
            w_hdr       = 1'b1;
            w_cnt_nxt   = data_in[6:0];
            w_state_nxt = data_in[7] ? S_RUN_VAL : S_LIT;
          end
        end
      end
      S_RUN_VAL: begin
        w_in_ready = enable && w_slot_free;
        if (in_valid && w_in_ready) begin
          w_load      = 1'b1;
          w_state_nxt = (r_cnt == 7'd0) ? S_HDR : S_RUN_OUT;
        end
      end
      S_RUN_OUT: begin
        if (enable && w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = r_val;
          w_cnt_nxt   = r_cnt - 7'd1;
          if (r_cnt == 7'd1) w_state_nxt = S_HDR;
        end
      end
      S_LIT: begin
        w_in_ready = enable && w_slot_free;
        if (in_valid && w_in_ready) begin
          w_load = 1'b1;
          if (r_cnt == 7'd0) w_state_nxt = S_HDR;
          else               w_cnt_nxt   = r_cnt - 7'd1;
        end
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HDR;
      r_cnt   <= 7'd0;
      r_val   <= 8'd0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_x     <= 12'd0;
      r_y     <= 12'd0;
      r_err   <= 1'b0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_RUN_VAL && w_load) r_val <= data_in;
      if (w_load) begin
        r_data  <= w_load_data;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_xfer) begin
        if (w_x_last) begin
          r_x <= 12'd0;
          r_y <= w_y_last ? 12'd0 : r_y + 12'd1;
        end else begin
          r_x <= r_x + 12'd1;
        end
      end
      if (r_state == S_HDR) r_err <= mode[1];
    end
  end

`ifdef RLE_DECOMP_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_cnt   <= 16'd0;
      r_frame_cnt <= 16'd0;
    end else if (enable) begin
      if (w_hdr) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_xfer && w_x_last && w_y_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign pkt_cnt   = r_pkt_cnt;
  assign frame_cnt = r_frame_cnt;
`endif

  // Reset gating keeps in_ready low while rst is held, independent of enable.
  assign in_ready  = rst && w_in_ready;
  assign data_out  = r_data;
  assign out_valid = r_valid;
  assign x         = r_x;
  assign y         = r_y;
  assign sof       = r_valid && (r_x == 12'd0) && (r_y == 12'd0);
  assign eol       = r_valid && w_x_last;
  assign err       = r_err;

endmodule
`default_nettype wire
